// File: rtl/mul16_seq_if.sv
// mul16_seq_if: request/response and ALU-side signals of the shift-add multiplier.
interface mul16_seq_if;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_cout;
    modport slave (
        input  start, multiplicand, multiplier, alu_result, alu_cout,
        output busy, done, product, alu_a, alu_b, alu_cin, alu_op
    );
    modport master (
        output start, multiplicand, multiplier, alu_result, alu_cout,
        input  busy, done, product, alu_a, alu_b, alu_cin, alu_op
    );
endinterface

// File: rtl/mul16_seq.sv
// mul16_seq: 16x16 unsigned shift-add multiplier using an external ALU for every add.
module mul16_seq #(
    parameter logic [2:0] ADD_OP = 3'b010
) (
    input logic       clk,
    input logic       rst_n,
    mul16_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, mcand_q, mcand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] shift_w;
    // 33-bit {cout, sum, acc_lo} shifted right by one; the dropped LSB is acc_lo[0]
    assign shift_w = {bus.alu_cout, bus.alu_result, acc_lo_q[15:1]};
    always_comb begin
        state_d  = state_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        if (state_q == RUN) begin
            acc_hi_d = shift_w[31:16];
            acc_lo_d = shift_w[15:0];
            cnt_d    = cnt_q + 4'd1;
            state_d  = (cnt_q == 4'd15) ? DONE : RUN;
        end else if (bus.start) begin
            acc_hi_d = 16'h0000;
            acc_lo_d = bus.multiplier;
            mcand_d  = bus.multiplicand;
            cnt_d    = 4'd0;
            state_d  = RUN;
        end else begin
            state_d  = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_hi_q <= 16'h0000;
            acc_lo_q <= 16'h0000;
            mcand_q  <= 16'h0000;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
        end
    end
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = {acc_hi_q, acc_lo_q};
    assign bus.alu_a   = acc_hi_q;
    assign bus.alu_b   = acc_lo_q[0] ? mcand_q : 16'h0000;
    assign bus.alu_cin = 1'b0;
    assign bus.alu_op  = ADD_OP;
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: directed vectors for mul16_seq with a behavioural adder standing in for the ALU.
module tb_mul16_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    mul16_seq_if bus();
    mul16_seq #(.ADD_OP(3'b010)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    assign {bus.alu_cout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0000, bus.alu_cin};
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        step();
        bus.start = 1'b0;
    endtask
    task automatic finish(input string tag, input int lat, input logic [31:0] prod);
        int n = 0;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_prod"}, bus.product, prod);
        check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    endtask
    initial begin
        int nb;
        int nd;
        bus.start = 1'b0;
        bus.multiplicand = 16'h0000;
        bus.multiplier = 16'h0000;
        step();
        step();
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_prod", bus.product, 32'd0);
        check("alu_op", {29'b0, bus.alu_op}, 32'd2);
        check("alu_cin", {31'b0, bus.alu_cin}, 32'd0);
        bus.start = 1'b1;
        bus.multiplicand = 16'd3;
        bus.multiplier = 16'd5;
        step();
        check("rst_vs_start_busy", {31'b0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_hold_busy", {31'b0, bus.busy}, 32'd0);
        // 3 x 5 with busy-cycle count
        launch(16'd3, 16'd5);
        check("m35_alu_b", {16'h0, bus.alu_b}, 32'd3);
        check("m35_alu_a", {16'h0, bus.alu_a}, 32'd0);
        nb = 0;
        nd = 0;
        while (!bus.done && nd < 40) begin
            if (bus.busy) nb++;
            step();
            nd++;
        end
        check("m35_lat", nd, 16);
        check("m35_busy_cycles", nb, 16);
        check("m35_prod", bus.product, 32'd15);
        step();
        check("m35_done_pulse", {31'b0, bus.done}, 32'd0);
        check("m35_hold", bus.product, 32'd15);
        launch(16'hFFFF, 16'hFFFF);
        finish("max", 16, 32'hFFFE0001);
        step();
        launch(16'h0000, 16'h1234);
        finish("zero_a", 16, 32'd0);
        step();
        launch(16'h1234, 16'h0000);
        finish("zero_b", 16, 32'd0);
        step();
        // start pulse while busy must be ignored
        launch(16'h00FF, 16'h0101);
        repeat (4) step();
        bus.start = 1'b1;
        bus.multiplicand = 16'h1111;
        bus.multiplier = 16'h2222;
        step();
        bus.start = 1'b0;
        finish("busy_start", 11, 32'h0000FFFF);
        step();
        // back-to-back with start held
        bus.start = 1'b1;
        bus.multiplicand = 16'd7;
        bus.multiplier = 16'd9;
        step();
        finish("b2b_first", 16, 32'd63);
        bus.multiplicand = 16'h8000;
        bus.multiplier = 16'd2;
        step();
        bus.start = 1'b0;
        check("b2b_restart_busy", {31'b0, bus.busy}, 32'd1);
        check("b2b_restart_done", {31'b0, bus.done}, 32'd0);
        finish("b2b_second", 16, 32'h00010000);
        step();
        // reset in the middle of an operation
        launch(16'd3, 16'd5);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'b0, bus.done}, 32'd0);
        check("mid_rst_prod", bus.product, 32'd0);
        nd = 0;
        repeat (20) begin
            step();
            if (bus.done) nd++;
        end
        check("mid_rst_no_done", nd, 0);
        launch(16'd300, 16'd200);
        finish("after_rst", 16, 32'd60000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
